// File: rtl/jt10_adpcm_addr_seq.sv
// ADPCM ROM nibble address sequencer: services CH time-multiplexed channels round-robin,
// one per cen slot, with start/end block registers, key-on/off, loop and half-rate modes.
module jt10_adpcm_addr_seq #(
  parameter int CH   = 6,
  parameter int SW   = 16,
  parameter int GRAN = 8,
  parameter int CHW  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic [CHW-1:0]     cpu_ch,
  input  logic [SW-1:0]      cpu_din,
  input  logic               up_start,
  input  logic               up_end,
  input  logic [CH-1:0]      kon,
  input  logic [CH-1:0]      koff,
  input  logic [CH-1:0]      loop_en,
  input  logic [CH-1:0]      half_en,
  input  logic [CH-1:0]      clr_flags,
  output logic [CHW-1:0]     slot,
  output logic [SW+GRAN-1:0] addr_out,
  output logic               nib_sel,
  output logic               roe_n,
  output logic               decon,
  output logic               clr,
  output logic [CH-1:0]      busy,
  output logic [CH-1:0]      flags
);

  localparam int             CW   = SW + GRAN + 1;
  localparam int             IW   = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CHW-1:0] LAST = CHW'(CH - 1);

  logic [SW-1:0]      r_start [CH];
  logic [SW-1:0]      r_end   [CH];
  logic [CW-1:0]      r_cnt   [CH];
  logic [CH-1:0]      r_on;
  logic [CH-1:0]      r_kon_p;
  logic [CH-1:0]      r_koff_p;
  logic [CH-1:0]      r_flags;
  logic [CHW-1:0]     r_s;
  logic               r_frame;
  logic [CHW-1:0]     r_slot;
  logic [SW+GRAN-1:0] r_addr;
  logic               r_nib;
  logic               r_roe_n;
  logic               r_decon;
  logic               r_clr;

  logic [IW-1:0]      w_idx;
  logic [IW-1:0]      w_cpu_idx;
  logic               w_cpu_ok;
  logic [CH-1:0]      w_sel;
  logic [CH-1:0]      w_consume;
  logic [CH-1:0]      w_set_mask;
  logic [CW-1:0]      w_cnt;
  logic [CW-1:0]      w_reload;
  logic [CW-1:0]      w_end_cnt;
  logic               w_nxt_on;
  logic [CW-1:0]      w_nxt_cnt;
  logic [SW+GRAN-1:0] w_nxt_addr;
  logic               w_nxt_nib;
  logic               w_nxt_roe_n;
  logic               w_nxt_decon;
  logic               w_nxt_clr;
  logic               w_set;

  assign w_idx     = r_s[IW-1:0];
  assign w_cpu_idx = cpu_ch[IW-1:0];
  assign w_cpu_ok  = (cpu_ch <= LAST);

  // Service decision for the channel in the current slot.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    w_sel       = '0;
    w_sel[w_idx] = 1'b1;
    w_cnt       = r_cnt[w_idx];
    w_reload    = {r_start[w_idx], {(GRAN+1){1'b0}}};
    w_end_cnt   = {r_end[w_idx], {(GRAN+1){1'b1}}};
    w_nxt_on    = r_on[w_idx];
    w_nxt_cnt   = w_cnt;
    w_nxt_addr  = r_addr;
    w_nxt_nib   = r_nib;
    w_nxt_roe_n = 1'b1;
    w_nxt_decon = 1'b0;
    w_nxt_clr   = 1'b0;
    w_set       = 1'b0;
    if (r_koff_p[w_idx]) begin
      w_nxt_on = 1'b0;
    end else if (r_kon_p[w_idx]) begin
      w_nxt_on  = 1'b1;
      w_nxt_cnt = w_reload;
      w_nxt_clr = 1'b1;
    end else if (r_on[w_idx] && (!half_en[w_idx] || !r_frame)) begin
      w_nxt_addr  = w_cnt[CW-1:1];
      w_nxt_nib   = w_cnt[0];
      w_nxt_roe_n = 1'b0;
      w_nxt_decon = 1'b1;
      if (w_cnt == w_end_cnt) begin
        w_set = 1'b1;
        if (loop_en[w_idx]) w_nxt_cnt = w_reload;
        else                w_nxt_on  = 1'b0;
      end else begin
        w_nxt_cnt = w_cnt + CW'(1);
      end
    end
    w_consume  = cen ? w_sel : '0;
    w_set_mask = (cen && w_set) ? w_sel : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the start/end/counter arrays are reset too, so a key-on after reset plays from 0.
      for (int i = 0; i < CH; i++) begin
        r_start[i] <= '0;
        r_end[i]   <= '0;
        r_cnt[i]   <= '0;
      end
      r_on     <= '0;
      r_kon_p  <= '0;
      r_koff_p <= '0;
      r_flags  <= '0;
      r_s      <= '0;
      r_frame  <= 1'b0;
      r_slot   <= '0;
      r_addr   <= '0;
      r_nib    <= 1'b0;
      r_roe_n  <= 1'b1;
      r_decon  <= 1'b0;
      r_clr    <= 1'b0;
    end else begin
      if (up_start && w_cpu_ok) r_start[w_cpu_idx] <= cpu_din;
      if (up_end && w_cpu_ok)   r_end[w_cpu_idx]   <= cpu_din;
      // Requests arriving on the serviced clock are kept for the next visit.
      r_kon_p  <= (r_kon_p & ~w_consume) | kon;
      r_koff_p <= (r_koff_p & ~w_consume) | koff;
      r_flags  <= (r_flags & ~clr_flags) | w_set_mask;
      if (cen) begin
        r_on[w_idx]  <= w_nxt_on;
        r_cnt[w_idx] <= w_nxt_cnt;
        r_slot       <= r_s;
        r_addr       <= w_nxt_addr;
        r_nib        <= w_nxt_nib;
        r_roe_n      <= w_nxt_roe_n;
        r_decon      <= w_nxt_decon;
        r_clr        <= w_nxt_clr;
        if (r_s == LAST) begin
          r_s     <= '0;
          r_frame <= ~r_frame;
        end else begin
          r_s <= r_s + CHW'(1);
        end
      end
    end
  end

  assign slot     = r_slot;
  assign addr_out = r_addr;
  assign nib_sel  = r_nib;
  assign roe_n    = r_roe_n;
  assign decon    = r_decon;
  assign clr      = r_clr;
  assign busy     = r_on;
  assign flags    = r_flags;

endmodule
